choice_sequencer: RTL and testbench

Upstream input stage for the cat/dog/chicken game. Debounces the confirm key and captures player 1's then player 2's one-hot choice from the shared switch bank. It presents the resulting 9-way one-hot scenario vector with a valid level to the round controller, and holds it until the controller acknowledges the round. This replaces direct sampling of the switches, so each player commits separately on the single shared `SW[2:0]` bank.

---
 rtl/choice_sequencer_if.sv | 10 +
 rtl/choice_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_choice_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/choice_sequencer_if.sv
// choice_sequencer_if: scenario handshake between the choice sequencer
// (master, presents the scenario) and the round controller (slave, acks it).
interface choice_sequencer_if;
  logic [8:0] scenario;
  logic       scenario_valid;
  logic       round_ack;

  modport master (output scenario, output scenario_valid, input round_ack);
  modport slave  (input scenario, input scenario_valid, output round_ack);
endinterface

// File: rtl/choice_sequencer.sv
// choice_sequencer: debounces the confirm key, captures player 1 and player 2
// one-hot choices from the shared switch bank and presents a 9-way one-hot
// scenario until the round controller acknowledges it.
// Optional feature macro: CPU_OPPONENT_EN (player 2 chosen by an 8-bit LFSR).
module choice_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [2:0]            sw_choice,
  input  logic                  confirm_n,
  choice_sequencer_if.master    ctl,
  output logic                  p1_locked,
  output logic                  p2_locked,
  output logic                  choice_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_P1, WAIT_P2, PRESENT} state_t;

  // synchronisers
  logic       r_conf_s1, r_conf_s2;
  logic [2:0] r_sw_s1, r_sw_s2;

  // debounce
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic [1:0]    r_flush;
  logic          r_armed;

  // FSM and latched choices
  state_t     r_state, w_state_next;
  logic [1:0] r_p1, r_p2, w_p1_next, w_p2_next;
  logic       w_err;
  logic       w_onehot;
  logic [1:0] w_sw_idx;
  logic [3:0] w_sum;
  logic [8:0] w_scen_dec;

  // registered outputs
  logic [8:0] r_scenario;
  logic       r_valid, r_p1_locked, r_p2_locked, r_err;

  // Two-flop synchronisers for the asynchronous key and switches
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_conf_s1 <= 1'b1;
      r_conf_s2 <= 1'b1;
      r_sw_s1   <= 3'b000;
      r_sw_s2   <= 3'b000;
    end else begin
      r_conf_s1 <= confirm_n;
      r_conf_s2 <= r_conf_s1;
      r_sw_s1   <= sw_choice;
      r_sw_s2   <= r_sw_s1;
    end
  end

  // Arming: after reset the key must be seen released (debounced) before a
  // press can register, so a key held through reset is not taken as a press.
  // r_flush waits until the synchroniser carries real input, not reset values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_flush <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (r_flush != 2'd2) r_flush <= r_flush + 2'd1;
      if (r_flush == 2'd2 && r_stable && r_conf_s2) r_armed <= 1'b1;
    end
  end

  // Debounce counter; a registered press strobe on an accepted 1->0 change
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_conf_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_conf_s2;
        r_cnt    <= '0;
        r_press  <= r_armed & ~r_conf_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign w_onehot = (r_sw_s2 == 3'b001) || (r_sw_s2 == 3'b010) || (r_sw_s2 == 3'b100);
  assign w_sw_idx = r_sw_s2[0] ? 2'd0 : (r_sw_s2[1] ? 2'd1 : 2'd2);

`ifdef CPU_OPPONENT_EN
  logic [7:0] r_lfsr;
  logic [1:0] w_cpu_idx;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk) begin
    if (!resetn) r_lfsr <= 8'h01;
    else         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_cpu_idx = 2'(r_lfsr % 8'd3);
`endif

  // Next-state logic: capture on valid presses, flag bad ones, clear on ack
  always_comb begin
    w_state_next = r_state;
    w_p1_next    = r_p1;
    w_p2_next    = r_p2;
    w_err        = 1'b0;
    case (r_state)
      WAIT_P1: begin
        if (r_press) begin
          if (w_onehot) begin
            w_p1_next = w_sw_idx;
`ifdef CPU_OPPONENT_EN
            w_p2_next    = w_cpu_idx;
            w_state_next = PRESENT;
`else
            w_state_next = WAIT_P2;
`endif
          end else begin
            w_err = 1'b1;
          end
        end
      end
      WAIT_P2: begin
        if (r_press) begin
          if (w_onehot) begin
            w_p2_next    = w_sw_idx;
            w_state_next = PRESENT;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      PRESENT: begin
        // presses here are dropped; ack wins even if a press coincides
        if (ctl.round_ack) begin
          w_p1_next    = 2'd0;
          w_p2_next    = 2'd0;
          w_state_next = WAIT_P1;
        end
      end
      default: w_state_next = WAIT_P1;
    endcase
  end

  // Scenario decode from next-state choices so outputs change with the state
  assign w_sum = 4'(w_p1_next) * 4'd3 + 4'(w_p2_next);

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_dec
      assign w_scen_dec[gi] = (w_sum == 4'(gi));
    end
  endgenerate

  // State, latches and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= WAIT_P1;
      r_p1        <= 2'd0;
      r_p2        <= 2'd0;
      r_scenario  <= 9'd0;
      r_valid     <= 1'b0;
      r_p1_locked <= 1'b0;
      r_p2_locked <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_p1        <= w_p1_next;
      r_p2        <= w_p2_next;
      r_scenario  <= (w_state_next == PRESENT) ? w_scen_dec : 9'd0;
      r_valid     <= (w_state_next == PRESENT);
      r_p1_locked <= (w_state_next != WAIT_P1);
      r_p2_locked <= (w_state_next == PRESENT);
      r_err       <= w_err;
    end
  end

  assign ctl.scenario       = r_scenario;
  assign ctl.scenario_valid = r_valid;
  assign p1_locked          = r_p1_locked;
  assign p2_locked          = r_p2_locked;
  assign choice_err         = r_err;

endmodule

// File: tb/tb_choice_sequencer.sv
// tb_choice_sequencer: randomized self-checking bench for choice_sequencer
// with DEBOUNCE_CYCLES=4. Expected values come from an abstract model of the
// game rules (chosen indices, press latency, LFSR polynomial).
module tb_choice_sequencer;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] sw_choice;
  logic       confirm_n;
  logic       p1_locked, p2_locked, choice_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_err_pulses = 0;

  logic [2:0] bad_tab [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  choice_sequencer_if bus ();

  choice_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sw_choice  (sw_choice),
    .confirm_n  (confirm_n),
    .ctl        (bus),
    .p1_locked  (p1_locked),
    .p2_locked  (p2_locked),
    .choice_err (choice_err)
  );

  always #5 clk = ~clk;

  // count error pulses (sampled mid-cycle)
  always @(negedge clk) if (choice_err === 1'b1) n_err_pulses++;

  // LFSR reference: x^8+x^6+x^5+x^4+1, seed 1, one step per clock
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (!resetn) m_lfsr <= 8'h01;
    else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int idx_of(input logic [2:0] c);
    return (c == 3'b001) ? 0 : ((c == 3'b010) ? 1 : 2);
  endfunction

  function automatic logic [8:0] scen_of(input int a, input int b);
    logic [8:0] one = 9'd1;
    return one << (3 * a + b);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // full debounced press and release with a given switch choice
  task automatic do_press(input logic [2:0] ch);
    sw_choice = ch;
    tick(3);
    confirm_n = 1'b0;
    tick(D + 6);
    confirm_n = 1'b1;
    tick(D + 6);
  endtask

  task automatic test_reset;
    resetn = 1'b0; confirm_n = 1'b1; sw_choice = 3'b000; bus.round_ack = 1'b0;
    tick(2);
    n_checks++; if (bus.scenario !== 9'd0) begin n_fail++; $display("FAIL reset_scenario: got %b want 0", bus.scenario); end
    n_checks++; if (bus.scenario_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.scenario_valid); end
    n_checks++; if (p1_locked !== 1'b0) begin n_fail++; $display("FAIL reset_p1: got %b want 0", p1_locked); end
    n_checks++; if (p2_locked !== 1'b0) begin n_fail++; $display("FAIL reset_p2: got %b want 0", p2_locked); end
    n_checks++; if (choice_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", choice_err); end
    resetn = 1'b1;
    tick(6);
    $display("reset released");
  endtask

  task automatic test_bounce;
    int e0;
    e0 = n_err_pulses;
    sw_choice = 3'b001;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      int len;
      len = $urandom_range(1, D - 1);
      confirm_n = 1'b0; tick(len);
      confirm_n = 1'b1; tick($urandom_range(1, 4));
      $display("glitch %0d low for %0d cycles", k, len);
    end
    tick(D + 4);
    n_checks++; if (p1_locked !== 1'b0) begin n_fail++; $display("FAIL bounce_p1: got %b want 0", p1_locked); end
    n_checks++; if (n_err_pulses !== e0) begin n_fail++; $display("FAIL bounce_err: got %0d pulses want %0d", n_err_pulses, e0); end
    for (int k = 0; k < 2; k++) begin
      logic [2:0] bad;
      bad = (k == 0) ? 3'b011 : bad_tab[$urandom_range(0, 4)];
      e0 = n_err_pulses;
      do_press(bad);
      $display("invalid press sw=%b", bad);
      n_checks++; if (n_err_pulses !== e0 + 1) begin n_fail++; $display("FAIL bad_err: got %0d pulses want %0d", n_err_pulses, e0 + 1); end
      n_checks++; if (p1_locked !== 1'b0) begin n_fail++; $display("FAIL bad_p1: got %b want 0", p1_locked); end
    end
  endtask

`ifndef CPU_OPPONENT_EN
  task automatic test_press_latency;
    sw_choice = 3'b001;
    tick(3);
    confirm_n = 1'b0;            // edge N
    tick(D + 2);                 // edge N+2+D: event cycle, lock not yet visible
    n_checks++; if (p1_locked !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %b want 0", p1_locked); end
    tick(1);                     // edge N+3+D
    n_checks++; if (p1_locked !== 1'b1) begin n_fail++; $display("FAIL latency_lock: got %b want 1", p1_locked); end
    n_checks++; if (p2_locked !== 1'b0) begin n_fail++; $display("FAIL latency_p2: got %b want 0", p2_locked); end
    confirm_n = 1'b1;
    tick(D + 6);
    $display("latency press p1=cat");
    // finish the round with p2=cat, then ack
    do_press(3'b001);
    n_checks++; if (bus.scenario !== scen_of(0, 0)) begin n_fail++; $display("FAIL latency_scen: got %b want %b", bus.scenario, scen_of(0, 0)); end
    bus.round_ack = 1'b1; tick(1); bus.round_ack = 1'b0;
    n_checks++; if (bus.scenario_valid !== 1'b0) begin n_fail++; $display("FAIL latency_ack: got %b want 0", bus.scenario_valid); end
  endtask

  task automatic test_full_round;
    do_press(3'b010);
    sw_choice = 3'b100;
    tick(3);
    confirm_n = 1'b0;
    tick(D + 2);
    n_checks++; if (bus.scenario_valid !== 1'b0) begin n_fail++; $display("FAIL round_pre_valid: got %b want 0", bus.scenario_valid); end
    tick(1);
    n_checks++; if (bus.scenario !== 9'b000100000) begin n_fail++; $display("FAIL round_scen: got %b want 000100000", bus.scenario); end
    n_checks++; if (bus.scenario_valid !== 1'b1 || p2_locked !== 1'b1) begin n_fail++; $display("FAIL round_enter: got valid=%b p2=%b want 1 1", bus.scenario_valid, p2_locked); end
    confirm_n = 1'b1;
    tick(D + 6);
    // held while unacked
    n_checks++; if (bus.scenario_valid !== 1'b1) begin n_fail++; $display("FAIL round_hold: got %b want 1", bus.scenario_valid); end
    bus.round_ack = 1'b1; tick(1); bus.round_ack = 1'b0;
    n_checks++; if ({bus.scenario_valid, p1_locked, p2_locked} !== 3'b000 || bus.scenario !== 9'd0) begin n_fail++; $display("FAIL round_ack: got valid/p1/p2=%b scen=%b want 000 0", {bus.scenario_valid, p1_locked, p2_locked}, bus.scenario); end
    $display("full round dog vs chicken acked");
  endtask

  task automatic test_random_rounds;
    for (int r = 0; r < 6; r++) begin
      logic [2:0] c1, c2;
      int e0;
      c1 = 3'b001 << $urandom_range(0, 2);
      c2 = 3'b001 << $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        e0 = n_err_pulses;
        do_press(bad_tab[$urandom_range(0, 4)]);
        n_checks++; if (n_err_pulses !== e0 + 1) begin n_fail++; $display("FAIL rnd_bad_err: got %0d want %0d", n_err_pulses, e0 + 1); end
      end
      do_press(c1);
      n_checks++; if ({p1_locked, p2_locked, bus.scenario_valid} !== 3'b100) begin n_fail++; $display("FAIL rnd_p1: got %b want 100", {p1_locked, p2_locked, bus.scenario_valid}); end
      do_press(c2);
      n_checks++; if (bus.scenario !== scen_of(idx_of(c1), idx_of(c2)) || bus.scenario_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_scen: got %b v=%b want %b v=1", bus.scenario, bus.scenario_valid, scen_of(idx_of(c1), idx_of(c2))); end
      sw_choice = 3'($urandom_range(0, 7));
      tick(5);
      n_checks++; if (bus.scenario !== scen_of(idx_of(c1), idx_of(c2))) begin n_fail++; $display("FAIL rnd_sw_change: got %b want %b", bus.scenario, scen_of(idx_of(c1), idx_of(c2))); end
      bus.round_ack = 1'b1; tick(1); bus.round_ack = 1'b0;
      n_checks++; if ({bus.scenario_valid, p1_locked, p2_locked} !== 3'b000) begin n_fail++; $display("FAIL rnd_ack: got %b want 000", {bus.scenario_valid, p1_locked, p2_locked}); end
      $display("round %0d p1=%b p2=%b", r, c1, c2);
    end
  endtask

  task automatic test_lock_hold;
    int e0;
    do_press(3'b001);
    do_press(3'b001);
    n_checks++; if (bus.scenario !== 9'b000000001) begin n_fail++; $display("FAIL hold_scen: got %b want 000000001", bus.scenario); end
    e0 = n_err_pulses;
    do_press(3'b010);
    do_press(3'b111);
    n_checks++; if (bus.scenario !== 9'b000000001 || bus.scenario_valid !== 1'b1) begin n_fail++; $display("FAIL hold_press: got %b v=%b want 000000001 v=1", bus.scenario, bus.scenario_valid); end
    n_checks++; if (n_err_pulses !== e0) begin n_fail++; $display("FAIL hold_err: got %0d want %0d", n_err_pulses, e0); end
    // press event and ack in the same cycle
    sw_choice = 3'b001;
    tick(3);
    confirm_n = 1'b0;
    tick(D + 2);
    bus.round_ack = 1'b1; tick(1); bus.round_ack = 1'b0;
    n_checks++; if ({bus.scenario_valid, p1_locked} !== 2'b00) begin n_fail++; $display("FAIL collide_ack: got %b want 00", {bus.scenario_valid, p1_locked}); end
    tick(D + 4);
    confirm_n = 1'b1;
    tick(D + 6);
    n_checks++; if (p1_locked !== 1'b0) begin n_fail++; $display("FAIL collide_discard: got %b want 0", p1_locked); end
    $display("lock hold and press/ack collision");
  endtask

  task automatic test_reset_mid_round;
    do_press(3'b100);
    sw_choice = 3'b010;
    tick(3);
    confirm_n = 1'b0;
    tick(3);
    resetn = 1'b0;
    tick(2);
    n_checks++; if ({p1_locked, p2_locked, bus.scenario_valid, choice_err} !== 4'b0000 || bus.scenario !== 9'd0) begin n_fail++; $display("FAIL midreset_out: got %b scen=%b want 0000 0", {p1_locked, p2_locked, bus.scenario_valid, choice_err}, bus.scenario); end
    resetn = 1'b1;
    tick(3 * D + 10);
    n_checks++; if (p1_locked !== 1'b0) begin n_fail++; $display("FAIL midreset_held: got %b want 0", p1_locked); end
    confirm_n = 1'b1;
    tick(D + 6);
    n_checks++; if (p1_locked !== 1'b0) begin n_fail++; $display("FAIL midreset_release: got %b want 0", p1_locked); end
    do_press(3'b010);
    n_checks++; if (p1_locked !== 1'b1) begin n_fail++; $display("FAIL midreset_repress: got %b want 1", p1_locked); end
    $display("reset mid-round recovered");
  endtask
`else
  task automatic test_cpu_rounds;
    for (int r = 0; r < 5; r++) begin
      logic [2:0] c1;
      logic [7:0] l_at;
      logic [8:0] want;
      c1 = 3'b001 << $urandom_range(0, 2);
      sw_choice = c1;
      tick($urandom_range(3, 9));
      confirm_n = 1'b0;
      tick(D + 2);
      l_at = m_lfsr;
      n_checks++; if (p1_locked !== 1'b0) begin n_fail++; $display("FAIL cpu_early: got %b want 0", p1_locked); end
      tick(1);
      want = scen_of(idx_of(c1), int'(l_at % 8'd3));
      n_checks++; if ({p1_locked, p2_locked, bus.scenario_valid} !== 3'b111) begin n_fail++; $display("FAIL cpu_locks: got %b want 111", {p1_locked, p2_locked, bus.scenario_valid}); end
      n_checks++; if (bus.scenario !== want) begin n_fail++; $display("FAIL cpu_scen: got %b want %b", bus.scenario, want); end
      confirm_n = 1'b1;
      tick(D + 6);
      bus.round_ack = 1'b1; tick(1); bus.round_ack = 1'b0;
      n_checks++; if ({bus.scenario_valid, p1_locked, p2_locked} !== 3'b000) begin n_fail++; $display("FAIL cpu_ack: got %b want 000", {bus.scenario_valid, p1_locked, p2_locked}); end
      $display("cpu round %0d p1=%b lfsr=%h", r, c1, l_at);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef CPU_OPPONENT_EN
    test_press_latency();
    test_full_round();
    test_bounce();
    test_random_rounds();
    test_lock_hold();
    test_reset_mid_round();
`else
    test_bounce();
    test_cpu_rounds();
`endif
    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end

endmodule
